carry_save_accumulator_seq: RTL
===============================

Name: carry_save_accumulator_seq

Overview:
- Streaming multi-operand adder. Accepts unsigned operands one per beat over a valid/ready input, and accumulates them in redundant carry-save form (one 3:2 compression per beat, no carry propagation).
- On the packet's last beat, it resolves the redundant pair to binary with a digit-serial 4-bit carry-lookahead pass, then presents the sum on a valid/ready output.
- It is the sequential, streaming counterpart of the team's combinational carry-save adders. It sits between an operand source and a downstream result consumer.

Parameters:
- WIDTH, 16, operand width in bits.
- EXT, 8, guard bits; accumulator width ACC_W = WIDTH+EXT. ACC_W must be a multiple of 4.
- K (localparam), ACC_W/4, number of resolve cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat
- in_data  input  WIDTH  unsigned operand, zero-extended to ACC_W
- in_last  input  1  beat is final operand of packet
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  sum of packet operands mod 2^ACC_W
- out_count  output  EXT+1  operands in packet, saturating at 2^(EXT+1)-1
- out_overflow  output  1  out_count > 2^EXT (sum may have wrapped)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset values: state=ACCUM; S, C, result, count = 0; in_ready=1; out_valid=0; out_sum=0; out_count=0; out_overflow=0.
- Reset mid-operation: reset is honoured in any state and dominates all other events. A partial packet or pending result is discarded.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid&in_ready.
  - Update: S' = S^C^X; C' = (maj(S,C,X) << 1) truncated to ACC_W; count' = sat(count+1).
  - If in_last on the accepted beat, go to RESOLVE with chunk index k=0 and carry register cr=0.
  - A single-beat packet is legal.
- RESOLVE state (K cycles):
  - in_ready=0.
  - Each cycle: {cr', result[4k+3:4k]} = S[4k+3:4k] + C[4k+3:4k] + cr, computed by the 4-bit CLA; then k++.
  - After chunk K-1, go to OUT. The final cr is discarded (mod 2^ACC_W).
- OUT state:
  - out_valid=1; out_sum, out_count, out_overflow stable and held while out_ready=0; in_ready=0.
  - On out_valid&out_ready: clear S, C, count; go to ACCUM (in_ready=1 next cycle).
- Latency: out_valid is first high K cycles after the edge accepting in_last (6 cycles at defaults). Throughput is one operand per cycle within a packet.
- No simultaneous accept/emit: input is blocked in RESOLVE and OUT, so a new packet never overlaps a pending result.
- in_data is ignored when in_valid=0. The in_last/in_data combination is only sampled on handshake.

Decomposition:
- Shared package, carry-save accumulator typedefs and constants:
  - state enum {ACCUM, RESOLVE, OUT}
  - CHUNK_W=4 constant
  - function maj3
- Sub-module: reuse the existing carry_lookahead_adder_4 as the per-chunk resolver (cin=cr, P/G unused).
- The CSA bit-slice is simple enough to stay inline.

Test Plan:
- Beats 1, 2, 3 (last on 3) -> out_sum=6, out_count=3, out_overflow=0, out_valid exactly 6 cycles after last handshake.
- Carry chain: 0xFFFF, 0x0001 (last) -> out_sum=0x010000, count=2. Checks cr propagation across chunks.
- 256 beats of 0xFFFF -> out_sum=0xFFFF00, count=256, overflow=0. 257 beats -> out_sum=0x00FEFF, count=257, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum stable, in_ready=0 throughout; offered in_valid beats are not consumed. Then out_ready=1 -> in_ready=1 next cycle.
- Reset mid-RESOLVE: rst_n=0 for 1 cycle during chunk 2 -> next cycle out_valid=0, in_ready=1. Then packet 5, 7 (last) -> out_sum=12, count=2.
- Back-to-back packets with out_ready tied 1: {10} then {20, 30} -> results 10 then 50, with no state leakage between packets.

Source files
------------

// File: rtl/carry_save_accumulator_seq_pkg.sv
// Shared constants and helpers for the streaming carry-save accumulator.
package carry_save_accumulator_seq_pkg;

  localparam int unsigned CHUNK_W = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_ACCUM   = 2'd0;
  localparam logic [STATE_W-1:0] ST_RESOLVE = 2'd1;
  localparam logic [STATE_W-1:0] ST_OUT     = 2'd2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_4.sv
// 4-bit carry-lookahead adder with group propagate/generate outputs.
module carry_lookahead_adder_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum_c,
  output logic       o_cout_c,
  output logic       o_p_c,
  output logic       o_g_c
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:1] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is expanded directly from P/G and cin, no ripple.
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_g_c  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_p_c  = &w_p;
  assign w_c[4] = o_g_c | (o_p_c & i_cin);

  assign o_sum_c  = w_p ^ {w_c[3:1], i_cin};
  assign o_cout_c = w_c[4];

endmodule

// File: rtl/carry_save_accumulator_seq.sv
// Streaming multi-operand adder: carry-save accumulation per beat, then a
// digit-serial CLA pass converts the redundant pair to binary on packet end.
module carry_save_accumulator_seq
  import carry_save_accumulator_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EXT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH+EXT-1:0]  out_sum,
  output logic [EXT:0]          out_count,
  output logic                  out_overflow
);

  localparam int unsigned ACC_W = WIDTH + EXT;
  localparam int unsigned K     = ACC_W / CHUNK_W;
  localparam int unsigned K_W   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CNT_W = EXT + 1;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [ACC_W-1:0]   r_s;
  logic [ACC_W-1:0]   r_c;
  logic [ACC_W-1:0]   r_result;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [K_W-1:0]     r_k;
  logic               r_cr;
  logic               r_in_ready;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_emit;
  logic               w_last_chunk;
  logic [ACC_W-1:0]   w_x;
  logic [ACC_W-1:0]   w_s_nxt;
  logic [ACC_W-1:0]   w_c_nxt;
  logic [CNT_W-1:0]   w_count_inc;
  logic [CHUNK_W-1:0] w_s_chunk;
  logic [CHUNK_W-1:0] w_c_chunk;
  logic [CHUNK_W-1:0] w_cla_sum;
  logic               w_cla_cout;
  logic               w_cla_p_unused;
  logic               w_cla_g_unused;

  assign w_last_chunk = (r_k == K_W'(K - 1));

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_accept = in_valid & r_in_ready;
        if (w_accept && in_last) w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (w_last_chunk) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_emit = r_out_valid & out_ready;
        if (w_emit) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_ACCUM);
      r_out_valid <= (w_state_nxt == ST_OUT);
    end
  end

  // One 3:2 compression per accepted beat; the top majority bit falls off.
  always_comb begin
    w_x     = ACC_W'(in_data);
    w_s_nxt = r_s ^ r_c ^ w_x;
    w_c_nxt = '0;
    for (int i = 0; i < int'(ACC_W) - 1; i++) begin
      w_c_nxt[i+1] = maj3(r_s[i], r_c[i], w_x[i]);
    end
  end

  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  assign w_s_chunk = r_s[r_k*CHUNK_W +: CHUNK_W];
  assign w_c_chunk = r_c[r_k*CHUNK_W +: CHUNK_W];

  carry_lookahead_adder_4 u_cla (
    .i_a      (w_s_chunk),
    .i_b      (w_c_chunk),
    .i_cin    (r_cr),
    .o_sum_c  (w_cla_sum),
    .o_cout_c (w_cla_cout),
    .o_p_c    (w_cla_p_unused),
    .o_g_c    (w_cla_g_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s        <= '0;
      r_c        <= '0;
      r_result   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_k        <= '0;
      r_cr       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s        <= w_s_nxt;
        r_c        <= w_c_nxt;
        r_count    <= w_count_inc;
        r_overflow <= (w_count_inc > CNT_W'(2 ** EXT));
        if (in_last) begin
          r_k  <= '0;
          r_cr <= 1'b0;
        end
      end
      if (r_state == ST_RESOLVE) begin
        r_result[r_k*CHUNK_W +: CHUNK_W] <= w_cla_sum;
        r_cr <= w_cla_cout;
        r_k  <= r_k + K_W'(1);
      end
      if (w_emit) begin
        r_s        <= '0;
        r_c        <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sum      = r_result;
  assign out_count    = r_count;
  assign out_overflow = r_overflow;

endmodule
